// File: rtl/raster_tri_rcu_pkg.sv
// rtl/raster_tri_rcu_pkg.sv - shared types and defaults for the triangle receive/issue block
package raster_tri_rcu_pkg;

  localparam int TRI_W_DEFAULT = 288;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } raster_state_t;

endpackage

// File: rtl/raster_tri_rcu_if.sv
// rtl/raster_tri_rcu_if.sv - upstream push, rasterizer handshake and status signals
interface raster_tri_rcu_if
  import raster_tri_rcu_pkg::*;
#(
  parameter int TRI_W = TRI_W_DEFAULT,
  parameter int DEPTH = 4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             triangle_ready;
  logic [TRI_W-1:0] tri_in;
  logic             raster_done;
  logic             start_raster;
  logic [TRI_W-1:0] tri_out;
  logic [CW-1:0]    count;
  logic             busy;
  logic             overflow;

  modport master (
    output triangle_ready, tri_in, raster_done,
    input  start_raster, tri_out, count, busy, overflow
  );

  modport slave (
    input  triangle_ready, tri_in, raster_done,
    output start_raster, tri_out, count, busy, overflow
  );

endinterface

// File: rtl/raster_tri_rcu_fifo.sv
// rtl/raster_tri_rcu_fifo.sv - triangle FIFO with separate occupancy counter and drop strobe
module tri_fifo #(
  parameter int TRI_W = 288,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [TRI_W-1:0]           wdata,
  output logic [TRI_W-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TRI_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign rdata = mem[rd_ptr];
  assign count = cnt;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/raster_tri_rcu.sv
// rtl/raster_tri_rcu.sv - buffers clip-and-split triangles and issues them to the rasterizer
module raster_tri_rcu
  import raster_tri_rcu_pkg::*;
#(
  parameter int TRI_W = TRI_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  raster_tri_rcu_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  raster_state_t    state;
  logic [TRI_W-1:0] tri_out_r;
  logic             start_r;
  logic             overflow_r;
  logic [TRI_W-1:0] head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full_unused;
  logic             fifo_empty;
  logic             fifo_drop;
  logic             pop;

  // Pops happen only on an FSM transition out of IDLE or out of BUSY on done.
  assign pop = !fifo_empty && ((state == IDLE) || ((state == BUSY) && bus.raster_done));

  tri_fifo #(
    .TRI_W (TRI_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (bus.triangle_ready),
    .pop   (pop),
    .wdata (bus.tri_in),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      tri_out_r  <= '0;
      start_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | fifo_drop;
      start_r    <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tri_out_r <= head;
            start_r   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          state <= BUSY;
        end
        BUSY: begin
          if (bus.raster_done) begin
            if (pop) begin
              tri_out_r <= head;
              start_r   <= 1'b1;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_raster = start_r;
  assign bus.tri_out      = tri_out_r;
  assign bus.count        = fifo_count;
  assign bus.overflow     = overflow_r;
  assign bus.busy         = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_raster_tri_rcu.sv
// tb/tb_raster_tri_rcu.sv - directed self-checking bench for raster_tri_rcu
module tb_raster_tri_rcu;

  localparam int TW = 288;
  localparam int D  = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  int total = 0;
  int bad   = 0;
  int last_peak;

  logic [TW-1:0] exp_q [$];

  raster_tri_rcu_if #(.TRI_W(TW), .DEPTH(D)) bus ();

  raster_tri_rcu #(.TRI_W(TW), .DEPTH(D)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] word(input int t);
    return {{8{32'hA5A5A5A5}}, t[31:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.triangle_ready = 1'b0;
    bus.raster_done    = 1'b0;
    bus.tri_in         = '0;
    n_rst = 1'b0;
    cyc();
    cyc();
    n_rst = 1'b1;
  endtask

  task automatic push_burst(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.triangle_ready = 1'b1;
      bus.tri_in         = word(first + i);
      cyc();
    end
    bus.triangle_ready = 1'b0;
  endtask

  // Expects the FSM in BUSY; each done must yield the next tag on the following cycle.
  task automatic drain(input int first, input int last, input string tag);
    for (int t = first; t <= last; t++) begin
      bus.raster_done = 1'b1;
      cyc();
      bus.raster_done = 1'b0;
      expect_eq({tag, " start"}, bus.start_raster, 1);
      expect_eq({tag, " tri_out"}, bus.tri_out, word(t));
      cyc();
    end
  endtask

  // Pushes exp_q every gap cycles and models a rasterizer that takes lat cycles per triangle.
  task automatic run_stream(input int lat, input int gap, input int n, input string tag);
    int issued = 0;
    int cyc_idx = 0;
    int done_at = -1;
    logic [TW-1:0] pq [$];
    pq = exp_q;
    last_peak = 0;
    while ((issued < n || cyc_idx <= done_at) && cyc_idx < 300) begin
      if (int'(bus.count) > last_peak) last_peak = int'(bus.count);
      if (bus.start_raster) begin
        if (issued < n) expect_eq({tag, " order"}, bus.tri_out, exp_q[issued]);
        else expect_eq({tag, " extra start"}, 1, 0);
        issued++;
        done_at = cyc_idx + lat - 1;
      end
      bus.triangle_ready = (pq.size() > 0) && (cyc_idx % gap == 0);
      if (bus.triangle_ready) bus.tri_in = pq.pop_front();
      bus.raster_done = (cyc_idx == done_at);
      cyc();
      cyc_idx++;
    end
    bus.triangle_ready = 1'b0;
    bus.raster_done    = 1'b0;
    expect_eq({tag, " issued"}, issued, n);
    expect_eq({tag, " busy end"}, bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;

    bus.triangle_ready = 1'b0;
    bus.raster_done    = 1'b0;
    bus.tri_in         = '0;
    #3;
    expect_eq("reset start", bus.start_raster, 0);
    expect_eq("reset tri_out", bus.tri_out, 0);
    expect_eq("reset count", bus.count, 0);
    expect_eq("reset busy", bus.busy, 0);
    expect_eq("reset overflow", bus.overflow, 0);
    cyc();
    cyc();
    n_rst = 1'b1;

    // single triangle
    bus.triangle_ready = 1'b1;
    bus.tri_in         = word(32'hA5);
    cyc();
    bus.triangle_ready = 1'b0;
    expect_eq("single c1 count", bus.count, 1);
    expect_eq("single c1 start", bus.start_raster, 0);
    cyc();
    expect_eq("single c2 start", bus.start_raster, 1);
    expect_eq("single c2 tri_out", bus.tri_out, word(32'hA5));
    expect_eq("single c2 count", bus.count, 0);
    cyc();
    expect_eq("single c3 start", bus.start_raster, 0);
    expect_eq("single c3 busy", bus.busy, 1);
    cyc();
    cyc();
    bus.raster_done = 1'b1;
    cyc();
    bus.raster_done = 1'b0;
    expect_eq("single c6 busy", bus.busy, 0);
    expect_eq("single c6 start", bus.start_raster, 0);
    expect_eq("single c6 tri_out held", bus.tri_out, word(32'hA5));

    // burst of three, 4-cycle rasterizer
    exp_q = '{word(1), word(2), word(3)};
    run_stream(4, 1, 3, "burst");
    expect_eq("burst peak count", last_peak, 2);
    expect_eq("burst overflow", bus.overflow, 0);

    // ten tags through the 4-deep ring
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(word(16 + i));
    run_stream(2, 2, 10, "wrap");
    expect_eq("wrap overflow", bus.overflow, 0);
    expect_eq("wrap count", bus.count, 0);

    // overflow: six pushes, no done
    do_reset();
    push_burst(32, 6);
    expect_eq("ovf count", bus.count, 4);
    expect_eq("ovf flag", bus.overflow, 1);
    expect_eq("ovf tri_out", bus.tri_out, word(32));
    expect_eq("ovf busy", bus.busy, 1);
    cyc();
    cyc();
    cyc();
    expect_eq("ovf sticky", bus.overflow, 1);
    drain(33, 36, "ovf drain");
    expect_eq("ovf drained count", bus.count, 0);
    bus.raster_done = 1'b1;
    cyc();
    bus.raster_done = 1'b0;
    expect_eq("ovf idle busy", bus.busy, 0);
    expect_eq("ovf idle start", bus.start_raster, 0);
    expect_eq("ovf still set", bus.overflow, 1);

    // push and pop on the same edge while full
    do_reset();
    push_burst(48, 5);
    expect_eq("full count", bus.count, 4);
    bus.triangle_ready = 1'b1;
    bus.tri_in         = word(53);
    bus.raster_done    = 1'b1;
    cyc();
    bus.triangle_ready = 1'b0;
    bus.raster_done    = 1'b0;
    expect_eq("full pushpop count", bus.count, 4);
    expect_eq("full pushpop overflow", bus.overflow, 0);
    expect_eq("full pushpop start", bus.start_raster, 1);
    expect_eq("full pushpop tri_out", bus.tri_out, word(49));
    cyc();
    drain(50, 53, "full drain");
    expect_eq("full drain overflow", bus.overflow, 0);
    expect_eq("full drain count", bus.count, 0);

    // asynchronous reset while BUSY with two queued
    do_reset();
    push_burst(64, 3);
    expect_eq("arst pre count", bus.count, 2);
    expect_eq("arst pre busy", bus.busy, 1);
    #3;
    n_rst = 1'b0;
    #1;
    expect_eq("arst start", bus.start_raster, 0);
    expect_eq("arst tri_out", bus.tri_out, 0);
    expect_eq("arst count", bus.count, 0);
    expect_eq("arst busy", bus.busy, 0);
    expect_eq("arst overflow", bus.overflow, 0);
    #2;
    n_rst = 1'b1;
    cyc();
    bus.raster_done = 1'b1;
    cyc();
    bus.raster_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (bus.start_raster) seen = 1'b1;
      cyc();
    end
    expect_eq("arst stray done start", seen, 0);
    expect_eq("arst stray done busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
